// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture front end.
// The frame type here matches the default configuration. The top defines
// its own frame type sized to its parameters and passes it to the FIFO.
package adc_capture_pkg;

    localparam int unsigned SEQ_W         = 8;
    localparam int unsigned DECIM_CFG_W   = 3;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_NUM_CH    = 1;
    localparam int unsigned DEF_MAX_DECIM = 7;
    localparam int unsigned DEF_ACC_W     = DEF_DATA_W + DEF_MAX_DECIM;
    localparam int unsigned DEF_CH_W      = DEF_NUM_CH * DEF_DATA_W;

    typedef struct packed {
        logic [DEF_CH_W-1:0] data;
        logic [SEQ_W-1:0]    seq;
    } frame_t;

    // Accumulator width that holds 2^max_decim full-scale samples.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned max_decim);
        return data_w + max_decim;
    endfunction

    // Packed width of one frame of channel words.
    function automatic int unsigned ch_width(input int unsigned data_w,
                                             input int unsigned num_ch);
        return data_w * num_ch;
    endfunction

    // Limit the requested decimation exponent to what the accumulator holds.
    function automatic logic [DECIM_CFG_W-1:0] clamp_decim(
        input logic [DECIM_CFG_W-1:0] req,
        input int unsigned            max_decim
    );
        if (32'(req) > max_decim)
            return DECIM_CFG_W'(max_decim);
        return req;
    endfunction

    // Clip a signed value into the unsigned range [0, 2^width-1].
    function automatic int sat_unsigned(input int value, input int unsigned width);
        int top;
        top = (1 << width) - 1;
        if (value < 0)
            return 0;
        if (value > top)
            return top;
        return value;
    endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// Synchronous show-ahead FIFO of frames with occupancy output.
// A push while full is accepted only when a pop happens in the same cycle.
module adc_capture_fifo
    import adc_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = adc_capture_pkg::frame_t
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_frame,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            wr_en;
    logic            rd_en;

    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_frame;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adc_capture_frontend.sv
// ADC capture front end: programmable adc_clock, per-strobe accumulation of
// NUM_CH channels, boxcar average of 2^n conversions, frame FIFO and stream.
// Optional feature macro: ADC_CAPTURE_OFFSET_EN (offset subtract + saturate,
// one extra pipeline stage, adds the cfg_offset port).
module adc_capture_frontend
    import adc_capture_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_CH     = 1,
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned MAX_DECIM  = 7,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cfg_enable,
    input  logic [DIV_W-1:0]              cfg_clk_div,
    input  logic [2:0]                    cfg_decim_log2,
    input  logic                          cfg_clear_ovf,
`ifdef ADC_CAPTURE_OFFSET_EN
    input  logic signed [DATA_W:0]        cfg_offset,
`endif
    output logic                          adc_clock,
    input  logic [NUM_CH*DATA_W-1:0]      adc_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*DATA_W-1:0]      out_data,
    output logic [7:0]                    out_seq,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);

    localparam int unsigned ACC_W  = acc_width(DATA_W, MAX_DECIM);
    localparam int unsigned CH_W   = ch_width(DATA_W, NUM_CH);
    localparam int unsigned DCNT_W = MAX_DECIM + 1;

    typedef struct packed {
        logic [CH_W-1:0]  data;
        logic [SEQ_W-1:0] seq;
    } frame_t;

    // Configuration capture
    logic               en_q;
    logic               enable_rise;
    logic [DIV_W-1:0]   div_q;
    logic [2:0]         decim_q;
    logic [DIV_W-1:0]   div_eff;
    logic [2:0]         decim_eff;

    // Divider and accumulation
    logic [DIV_W-1:0]   div_cnt;
    logic               terminal;
    logic               strobe;
    logic [DCNT_W-1:0]  dec_cnt;
    logic [DCNT_W-1:0]  decim_mask;
    logic               last_sample;
    logic [ACC_W-1:0]   acc     [NUM_CH];
    logic [ACC_W-1:0]   sum     [NUM_CH];
    logic [ACC_W-1:0]   shifted [NUM_CH];
    logic [CH_W-1:0]    avg_word;

    // Frame pipeline and FIFO side
    logic               frm_vld;
    logic [CH_W-1:0]    frm_data;
    logic               push;
    logic [CH_W-1:0]    push_data;
    frame_t             push_frame;
    frame_t             head;
    logic               pop;
    logic               full;
    logic               empty;
    logic               drop;
    logic [SEQ_W-1:0]   seq_q;

    // The rise cycle uses the incoming configuration directly so the divider
    // starts counting with the new value in the same cycle it is latched.
    assign enable_rise = cfg_enable && !en_q;
    assign div_eff     = enable_rise ? cfg_clk_div : div_q;
    assign decim_eff   = enable_rise ? clamp_decim(cfg_decim_log2, MAX_DECIM) : decim_q;

    // Latch configuration on the rising edge of cfg_enable only.
    always_ff @(posedge clock) begin
        if (reset) begin
            en_q    <= 1'b0;
            div_q   <= '0;
            decim_q <= '0;
        end else begin
            en_q <= cfg_enable;
            if (enable_rise) begin
                div_q   <= cfg_clk_div;
                decim_q <= clamp_decim(cfg_decim_log2, MAX_DECIM);
            end
        end
    end

    assign terminal = (div_cnt == div_eff);
    assign strobe   = cfg_enable && terminal && adc_clock;

    // Divider: toggle adc_clock on each terminal count, held low when disabled.
    always_ff @(posedge clock) begin
        if (reset || !cfg_enable) begin
            div_cnt   <= '0;
            adc_clock <= 1'b0;
        end else if (terminal) begin
            div_cnt   <= '0;
            adc_clock <= ~adc_clock;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Running sums including the current sample, and the truncated average.
    always_comb begin
        avg_word    = '0;
        decim_mask  = DCNT_W'((32'd1 << decim_eff) - 32'd1);
        last_sample = (dec_cnt == decim_mask);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            sum[k]     = acc[k] + ACC_W'(adc_data[k*DATA_W +: DATA_W]);
            shifted[k] = sum[k] >> decim_eff;
            avg_word[k*DATA_W +: DATA_W] = shifted[k][DATA_W-1:0];
        end
    end

    // Accumulate per strobe; restart on the strobe that completes a frame.
    always_ff @(posedge clock) begin
        if (reset || !cfg_enable) begin
            dec_cnt <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++)
                acc[k] <= '0;
        end else if (strobe) begin
            if (last_sample) begin
                dec_cnt <= '0;
                for (int unsigned k = 0; k < NUM_CH; k++)
                    acc[k] <= '0;
            end else begin
                dec_cnt <= dec_cnt + 1'b1;
                for (int unsigned k = 0; k < NUM_CH; k++)
                    acc[k] <= sum[k];
            end
        end
    end

    // Register the completed frame; it is offered to the FIFO next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            frm_vld  <= 1'b0;
            frm_data <= '0;
        end else begin
            frm_vld <= strobe && last_sample;
            if (strobe && last_sample)
                frm_data <= avg_word;
        end
    end

`ifdef ADC_CAPTURE_OFFSET_EN
    logic signed [DATA_W:0] offset_q;
    logic [CH_W-1:0]        off_word;
    logic [CH_W-1:0]        off_data;
    logic                   off_vld;

    // Offset is captured alongside the other configuration.
    always_ff @(posedge clock) begin
        if (reset)
            offset_q <= '0;
        else if (enable_rise)
            offset_q <= cfg_offset;
    end

    // Subtract the offset per channel and clip to the unsigned word range.
    always_comb begin
        off_word = '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
            off_word[k*DATA_W +: DATA_W] = DATA_W'(sat_unsigned(
                int'({1'b0, frm_data[k*DATA_W +: DATA_W]}) - int'(offset_q), DATA_W));
    end

    // Extra stage holding the offset-corrected frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            off_vld  <= 1'b0;
            off_data <= '0;
        end else begin
            off_vld <= frm_vld;
            if (frm_vld)
                off_data <= off_word;
        end
    end

    assign push      = off_vld;
    assign push_data = off_data;
`else
    assign push      = frm_vld;
    assign push_data = frm_data;
`endif

    // Tag each offered frame with the current sequence number.
    always_comb begin
        push_frame      = '0;
        push_frame.data = push_data;
        push_frame.seq  = seq_q;
    end

    assign pop  = out_valid && out_ready;
    assign drop = push && full && !pop;

    // Sequence advances for every offered frame, dropped or not.
    always_ff @(posedge clock) begin
        if (reset)
            seq_q <= '0;
        else if (push)
            seq_q <= seq_q + 1'b1;
    end

    // Sticky overflow and saturating drop counter; a drop beats a clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (cfg_clear_ovf)
                drop_count <= 8'd1;
            else if (drop_count != 8'hFF)
                drop_count <= drop_count + 1'b1;
        end else if (cfg_clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    adc_capture_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (frame_t)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_frame (push_frame),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .level      (fifo_level)
    );

    assign out_valid = !empty;
    assign out_data  = head.data;
    assign out_seq   = head.seq;

endmodule

// File: tb/tb_adc_capture_frontend.sv
// Directed self-checking bench for adc_capture_frontend (NUM_CH=2, DEPTH=4).
module tb_adc_capture_frontend;

`ifdef ADC_CAPTURE_OFFSET_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clock;
    logic        reset;
    logic        cfg_enable;
    logic [7:0]  cfg_clk_div;
    logic [2:0]  cfg_decim_log2;
    logic        cfg_clear_ovf;
    logic signed [8:0] cfg_offset;
    logic        adc_clock;
    logic [15:0] adc_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_seq;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    adc_capture_frontend #(
        .DATA_W     (8),
        .NUM_CH     (2),
        .DIV_W      (8),
        .MAX_DECIM  (7),
        .FIFO_DEPTH (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_enable     (cfg_enable),
        .cfg_clk_div    (cfg_clk_div),
        .cfg_decim_log2 (cfg_decim_log2),
        .cfg_clear_ovf  (cfg_clear_ovf),
`ifdef ADC_CAPTURE_OFFSET_EN
        .cfg_offset     (cfg_offset),
`endif
        .adc_clock      (adc_clock),
        .adc_data       (adc_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_seq        (out_seq),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; cfg_enable = 1'b0; cfg_clk_div = 8'd1; cfg_decim_log2 = 3'd0;
        cfg_clear_ovf = 1'b0; cfg_offset = 9'sd0; adc_data = 16'h125A; out_ready = 1'b0;
        step(2);

        // 1: run with ready low, then reset while adc_clock is high
        reset = 1'b0; cfg_enable = 1'b1;
        step(14);
        chk("pre_reset_level", 64'(fifo_level), 64'd3);
        chk("pre_reset_adc_clock", 64'(adc_clock), 64'd1);
        reset = 1'b1;
        step(1);
        chk("rst_adc_clock", 64'(adc_clock), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fifo_level", 64'(fifo_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_out_seq", 64'(out_seq), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);

        // 2: div=1, decim=0, period 4, one frame per period
        reset = 1'b0; out_ready = 1'b1;
        step(2);
        chk("t2_clk_e2", 64'(adc_clock), 64'd1);
        step(1);
        chk("t2_clk_e3", 64'(adc_clock), 64'd1);
        step(1);
        chk("t2_clk_e4", 64'(adc_clock), 64'd0);
        chk("t2_valid_t1", 64'(out_valid), 64'd0);
        step(1 + LAT);
        chk("t2_valid_t2", 64'(out_valid), 64'd1);
        chk("t2_data0", 64'(out_data), 64'h125A);
        chk("t2_seq0", 64'(out_seq), 64'd0);
        step(1);
        chk("t2_popped", 64'(out_valid), 64'd0);
        step(3);
        chk("t2_seq1", 64'(out_seq), 64'd1);
        chk("t2_valid1", 64'(out_valid), 64'd1);
        step(4);
        chk("t2_seq2", 64'(out_seq), 64'd2);
        chk("t2_data2", 64'(out_data), 64'h125A);

        // 3: partial frame aborted, then fresh decim=2 average
        reset = 1'b1; cfg_enable = 1'b0; out_ready = 1'b0;
        step(2);
        reset = 1'b0; cfg_decim_log2 = 3'd2; adc_data = {8'hFF, 8'd200}; cfg_enable = 1'b1;
        step(8);
        cfg_enable = 1'b0;
        step(3);
        chk("t3_abort_valid", 64'(out_valid), 64'd0);
        chk("t3_abort_level", 64'(fifo_level), 64'd0);
        chk("t3_abort_clk", 64'(adc_clock), 64'd0);
        adc_data = {8'hFF, 8'd10}; cfg_enable = 1'b1;
        step(1);
        cfg_decim_log2 = 3'd0;
        step(3);
        adc_data = {8'hFF, 8'd20};
        step(4);
        adc_data = {8'hFF, 8'd30};
        step(4);
        adc_data = {8'hFF, 8'd40};
        step(4 + LAT);
        chk("t3_valid_early", 64'(out_valid), 64'd0);
        step(1);
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_avg", 64'(out_data), 64'hFF19);
        chk("t3_seq", 64'(out_seq), 64'd0);

        // 4: overflow with ready low, drain, sequence gap
        reset = 1'b1; cfg_enable = 1'b0; out_ready = 1'b0;
        step(2);
        reset = 1'b0; cfg_decim_log2 = 3'd0; adc_data = 16'h125A; cfg_enable = 1'b1;
        step(17 + LAT);
        chk("t4_level_full", 64'(fifo_level), 64'd4);
        chk("t4_no_ovf_yet", 64'(overflow), 64'd0);
        step(4);
        chk("t4_level", 64'(fifo_level), 64'd4);
        chk("t4_overflow", 64'(overflow), 64'd1);
        chk("t4_drop_count", 64'(drop_count), 64'd1);
        chk("t4_hold_seq", 64'(out_seq), 64'd0);
        cfg_enable = 1'b0; out_ready = 1'b1;
        for (int s = 0; s < 4; s++) begin
            chk("t4_drain_seq", 64'(out_seq), 64'(s));
            step(1);
        end
        chk("t4_drained", 64'(out_valid), 64'd0);
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);
        cfg_enable = 1'b1;
        step(5 + LAT);
        chk("t4_next_valid", 64'(out_valid), 64'd1);
        chk("t4_next_seq", 64'(out_seq), 64'd5);
        cfg_enable = 1'b0; cfg_clear_ovf = 1'b1;
        step(1);
        cfg_clear_ovf = 1'b0;
        chk("t4_clr_ovf", 64'(overflow), 64'd0);
        chk("t4_clr_drop", 64'(drop_count), 64'd0);

        // 5: full FIFO with simultaneous pop and write; then drop vs clear
        reset = 1'b1; out_ready = 1'b0;
        step(2);
        reset = 1'b0; cfg_enable = 1'b1;
        step(17 + LAT);
        chk("t5_full", 64'(fifo_level), 64'd4);
        step(3);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t5_level_same", 64'(fifo_level), 64'd4);
        chk("t5_no_ovf", 64'(overflow), 64'd0);
        chk("t5_no_drop", 64'(drop_count), 64'd0);
        chk("t5_head_seq", 64'(out_seq), 64'd1);
        step(3);
        cfg_clear_ovf = 1'b1;
        step(1);
        cfg_clear_ovf = 1'b0;
        chk("t5_drop_wins_ovf", 64'(overflow), 64'd1);
        chk("t5_drop_wins_cnt", 64'(drop_count), 64'd1);
        cfg_enable = 1'b0;

`ifdef ADC_CAPTURE_OFFSET_EN
        // 6: offset subtract with saturation at both ends
        reset = 1'b1;
        step(2);
        reset = 1'b0; cfg_offset = 9'sh030; adc_data = {8'h50, 8'h20}; cfg_enable = 1'b1;
        step(5);
        chk("t6_valid_t2", 64'(out_valid), 64'd0);
        step(1);
        chk("t6_valid_t3", 64'(out_valid), 64'd1);
        chk("t6_sat_low", 64'(out_data), 64'h2000);
        reset = 1'b1; cfg_enable = 1'b0;
        step(2);
        reset = 1'b0; cfg_offset = -9'sd5; adc_data = {8'h10, 8'hFE}; cfg_enable = 1'b1;
        step(6);
        chk("t6_sat_high", 64'(out_data), 64'h15FF);
        cfg_enable = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
